// File: rtl/alu_sequencer.sv
// alu_sequencer: drives the shared 8-bit ALU one byte per cycle for narrow (1 pass) or wide (2 pass, carry-chained) ops.
// Latency: result valid 2 cycles after accept (narrow), 3 cycles (wide); held until res_ready.
// Backpressure: req_ready is low from accept until the result handshake; result outputs hold stable in DONE.
// Optional N/Z result flags are built when ALU_SEQ_FLAGS_EN is defined; otherwise res_n/res_z are tied 0.
// The op code is passed through to the ALU opaquely, so no operation encodings are needed here.
module alu_sequencer (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic        req_carry,
  input  logic        req_wide,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_y,
  output logic        res_carry,
  output logic        res_overflow,
  output logic        res_n,
  output logic        res_z,
  output logic [2:0]  alu_control,
  output logic [7:0]  alu_AI,
  output logic [7:0]  alu_BI,
  output logic        alu_carry_in,
  input  logic [7:0]  alu_Y,
  input  logic        alu_carry_out,
  input  logic        alu_overflow
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t     state;
  logic [7:0] a_hi;
  logic [7:0] b_hi;
  logic       wide;

  // Sequencer FSM: every output is registered, so the ALU drive for a pass is
  // loaded on the edge that enters that pass and cleared on the edge leaving it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      res_valid    <= 1'b0;
      res_y        <= 16'h0000;
      res_carry    <= 1'b0;
      res_overflow <= 1'b0;
      alu_control  <= 3'd0;
      alu_AI       <= 8'h00;
      alu_BI       <= 8'h00;
      alu_carry_in <= 1'b0;
      a_hi         <= 8'h00;
      b_hi         <= 8'h00;
      wide         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            // Low bytes go straight into the ALU drive for the LO pass; the
            // high bytes wait in a_hi/b_hi for a possible HI pass.
            alu_control  <= req_op;
            alu_AI       <= req_a[7:0];
            alu_BI       <= req_b[7:0];
            alu_carry_in <= req_carry;
            a_hi         <= req_a[15:8];
            b_hi         <= req_b[15:8];
            wide         <= req_wide;
            req_ready    <= 1'b0;
            state        <= LO;
          end
        end
        LO: begin
          res_y[7:0] <= alu_Y;
          if (wide) begin
            // The registered carry-in doubles as the stored LO-pass carry-out.
            alu_AI       <= a_hi;
            alu_BI       <= b_hi;
            alu_carry_in <= alu_carry_out;
            state        <= HI;
          end else begin
            res_y[15:8]  <= 8'h00;
            res_carry    <= alu_carry_out;
            res_overflow <= alu_overflow;
            alu_AI       <= 8'h00;
            alu_BI       <= 8'h00;
            alu_carry_in <= 1'b0;
            res_valid    <= 1'b1;
            state        <= DONE;
          end
        end
        HI: begin
          res_y[15:8]  <= alu_Y;
          res_carry    <= alu_carry_out;
          res_overflow <= alu_overflow;
          alu_AI       <= 8'h00;
          alu_BI       <= 8'h00;
          alu_carry_in <= 1'b0;
          res_valid    <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  // N/Z flags: LO computes byte flags (final for narrow); HI overrides with
  // the 16-bit view, Z combining the stored low byte with the high pass.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      res_n <= 1'b0;
      res_z <= 1'b0;
    end else if (state == LO) begin
      res_n <= alu_Y[7];
      res_z <= (alu_Y == 8'h00);
    end else if (state == HI) begin
      res_n <= alu_Y[7];
      res_z <= (alu_Y == 8'h00) && (res_y[7:0] == 8'h00);
    end
  end
`else
  assign res_n = 1'b0;
  assign res_z = 1'b0;
`endif

endmodule
